cache_refill_ctrl: RTL and testbench

- Miss/write-through controller between the CPU data port, the direct-mapped data cache and main memory.
- On a read hit it returns cache data in the same cycle.
- On a read miss it stalls the CPU, fetches the word from memory over a valid/ready request plus valid response interface, fills the cache line and returns the word.
- On a write it updates the cache (write-allocate) and forwards the write to memory, stalling until memory accepts.

---
 rtl/cache_refill_ctrl_if.sv | 59 +++++
 rtl/cache_refill_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill_ctrl_if
//  Description : Bundle of the CPU data port, data-cache port and main-memory
//                request/response port seen by the cache refill controller.
//                Modport 'master' is the controller's view: it drives the CPU
//                read data and stall, the cache write port and the memory
//                request.
//                Modport 'slave' is the environment's view: the CPU, the
//                cache arrays and the memory.
//  Parameters  : DATA_WIDTH - data word width
//                ADDR_WIDTH - byte address width
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_refill_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // CPU data port
    logic                  cpu_req_valid;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_stall;
    // Direct-mapped data cache
    logic                  cache_hit;
    logic [DATA_WIDTH-1:0] cache_rdata;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [DATA_WIDTH-1:0] cache_wdata;
    logic                  cache_we;
    // Main memory
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport master (
        input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
        input  cache_hit, cache_rdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output cpu_rdata, cpu_stall,
        output cache_addr, cache_wdata, cache_we,
        output mem_req_valid, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
        output cache_hit, cache_rdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  cpu_rdata, cpu_stall,
        input  cache_addr, cache_wdata, cache_we,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata
    );
endinterface : cache_refill_ctrl_if
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill_ctrl
//  Description : Miss / write-through controller between the CPU data port,
//                a direct-mapped data cache and main memory.
//                  - read hit  : cache data returned in the request cycle
//                  - read miss : stall, fetch one word from memory, fill the
//                                cache line and return the word
//                  - write     : write-allocate into the cache and forward
//                                the write to memory, stalling until accepted
//  Ports       : clk       - clock, rising edge
//                reset     - asynchronous active-low reset
//                bus       - cache_refill_ctrl_if.master (CPU/cache/memory)
//                hit_count / miss_count - 32-bit saturating read hit/miss
//                            counters, present only when CACHE_PERF_CNT_EN
//                            is defined
//  Options     : `define CACHE_PERF_CNT_EN to add the performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  wire                    clk,
    input  wire                    reset,
    cache_refill_ctrl_if.master    bus
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_FILL    = 3'd3,
        S_WR_REQ  = 3'd4
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_fill;
    logic                  r_mem_req_valid;
    logic                  r_mem_we;

    // Request classification, only meaningful in IDLE
    logic w_wr;
    logic w_rd_hit;
    logic w_rd_miss;

    assign w_wr      = bus.cpu_req_valid &  bus.cpu_we;
    assign w_rd_hit  = bus.cpu_req_valid & ~bus.cpu_we &  bus.cache_hit;
    assign w_rd_miss = bus.cpu_req_valid & ~bus.cpu_we & ~bus.cache_hit;

    // The latched address/data registers double as the memory request
    // fields so that the request is held stable for the whole handshake.
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wdata     = r_wdata;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_fill          <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr) begin
                        r_addr          <= bus.cpu_addr;
                        r_wdata         <= bus.cpu_wdata;
                        r_mem_req_valid <= 1'b1;
                        r_mem_we        <= 1'b1;
                        r_state         <= S_WR_REQ;
                    end else if (w_rd_miss) begin
                        r_addr          <= bus.cpu_addr;
                        r_mem_req_valid <= 1'b1;
                        r_mem_we        <= 1'b0;
                        r_state         <= S_RD_REQ;
                    end
                end
                // Any response arriving before the request is accepted is
                // stale and deliberately not looked at here.
                S_RD_REQ: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        r_fill  <= bus.mem_resp_data;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_state <= S_IDLE;
                end
                S_WR_REQ: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_mem_we        <= 1'b0;
                        r_state         <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Zero-latency CPU / cache side outputs. They are forced quiet while
    // reset is asserted so a request presented during reset can neither
    // stall the CPU nor write the cache.
    // ------------------------------------------------------------------
    always_comb begin
        bus.cpu_rdata   = '0;
        bus.cpu_stall   = 1'b0;
        bus.cache_we    = 1'b0;
        bus.cache_wdata = '0;
        bus.cache_addr  = (r_state == S_IDLE) ? bus.cpu_addr : r_addr;
        if (reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr) begin
                        // Write-allocate: update the line in the request cycle
                        bus.cache_we    = 1'b1;
                        bus.cache_wdata = bus.cpu_wdata;
                        bus.cpu_stall   = 1'b1;
                    end else if (w_rd_miss) begin
                        bus.cpu_stall   = 1'b1;
                    end else if (w_rd_hit) begin
                        bus.cpu_rdata   = bus.cache_rdata;
                    end
                end
                S_RD_REQ, S_RD_WAIT: begin
                    bus.cpu_stall = 1'b1;
                end
                S_FILL: begin
                    bus.cache_we    = 1'b1;
                    bus.cache_wdata = r_fill;
                    bus.cpu_rdata   = r_fill;
                end
                S_WR_REQ: begin
                    // The stall is released in the acceptance cycle itself
                    bus.cpu_stall = ~bus.mem_req_ready;
                end
                default: begin
                    bus.cpu_stall = 1'b0;
                end
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating read hit / miss counters, sampled only in IDLE so that a
    // held request is counted exactly once.
    // ------------------------------------------------------------------
    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (w_rd_hit && (r_hit_count != C_CNT_MAX)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_rd_miss && (r_miss_count != C_CNT_MAX)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    // Counters not built
`endif

endmodule : cache_refill_ctrl
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_refill_ctrl
//  Description : Self-checking testbench for cache_refill_ctrl. Expected CPU
//                read data and expected memory writes are queued when the
//                stimulus is driven and popped when the controller produces
//                them. Build with +define+CACHE_PERF_CNT_EN to also exercise
//                the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;
    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_refill_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_refill_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] q_rd[$];
    wr_t           q_wr[$];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req_valid  = 1'b0;
        bus.cpu_we         = 1'b0;
        bus.cpu_addr       = '0;
        bus.cpu_wdata      = '0;
        bus.cache_hit      = 1'b0;
        bus.cache_rdata    = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    // One cycle with no request: everything must be quiet
    task automatic idle_cycle();
        next_cycle();
        idle_inputs();
        #3;
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b expected 0", bus.cpu_stall); end
        checks++; if (bus.cache_we !== 1'b0) begin errors++; $display("FAIL idle_cache_we: got %b expected 0", bus.cache_we); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_mem_req_valid: got %b expected 0", bus.mem_req_valid); end
        checks++; if (bus.cpu_rdata !== '0) begin errors++; $display("FAIL idle_cpu_rdata: got %h expected 0", bus.cpu_rdata); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.cpu_req_valid  = 1'b1;
            bus.cpu_we         = 1'($urandom_range(0, 1));
            bus.cpu_addr       = $urandom;
            bus.cpu_wdata      = $urandom;
            bus.cache_hit      = 1'($urandom_range(0, 1));
            bus.cache_rdata    = $urandom;
            bus.mem_req_ready  = 1'($urandom_range(0, 1));
            bus.mem_resp_valid = 1'($urandom_range(0, 1));
            bus.mem_resp_data  = $urandom;
            #3;
            checks++; if (bus.cache_we !== 1'b0) begin errors++; $display("FAIL rst_cache_we: got %b expected 0", bus.cache_we); end
            checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_req_valid: got %b expected 0", bus.mem_req_valid); end
            checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_cpu_stall: got %b expected 0", bus.cpu_stall); end
            next_cycle();
        end
        idle_inputs();
        reset = 1'b1;
        #3;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== '0) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", bus.mem_wdata); end
        idle_cycle();
    endtask

    task automatic test_read_hit(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic [DW-1:0] exp;
        next_cycle();
        idle_inputs();
        bus.cpu_req_valid = 1'b1;
        bus.cpu_addr      = addr;
        bus.cache_hit     = 1'b1;
        bus.cache_rdata   = data;
        q_rd.push_back(data);
        #3;
        checks++; if (bus.cache_addr !== addr) begin errors++; $display("FAIL hit_cache_addr: got %h expected %h", bus.cache_addr, addr); end
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL hit_stall: got %b expected 0", bus.cpu_stall); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL hit_mem_req_valid: got %b expected 0", bus.mem_req_valid); end
        checks++; if (bus.cache_we !== 1'b0) begin errors++; $display("FAIL hit_cache_we: got %b expected 0", bus.cache_we); end
        checks++;
        if (q_rd.size() == 0) begin
            errors++; $display("FAIL hit_scoreboard: got empty queue expected entry");
        end else begin
            exp = q_rd.pop_front();
            if (bus.cpu_rdata !== exp) begin errors++; $display("FAIL hit_cpu_rdata: got %h expected %h", bus.cpu_rdata, exp); end
        end
    endtask

    // Read miss with rdy_dly not-ready cycles and resp_dly empty wait cycles
    task automatic test_read_miss(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                  input int rdy_dly, input int resp_dly);
        logic [DW-1:0] exp;
        next_cycle();
        idle_inputs();
        bus.cpu_req_valid = 1'b1;
        bus.cpu_addr      = addr;
        bus.cache_rdata   = 32'hBAD0_BAD0;
        q_rd.push_back(data);
        #3;
        checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL miss_req_stall: got %b expected 1", bus.cpu_stall); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL miss_req_mem_valid: got %b expected 0", bus.mem_req_valid); end
        checks++; if (bus.cache_we !== 1'b0) begin errors++; $display("FAIL miss_req_cache_we: got %b expected 0", bus.cache_we); end
        for (int i = 0; i <= rdy_dly; i++) begin
            next_cycle();
            bus.mem_req_ready  = (i == rdy_dly);
            // A stray response before acceptance must be ignored
            bus.mem_resp_valid = (i == 0);
            bus.mem_resp_data  = 32'hBAD1_BAD1;
            #3;
            checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL miss_mem_req: got valid=%b we=%b expected valid=1 we=0", bus.mem_req_valid, bus.mem_we); end
            checks++; if (bus.mem_addr !== addr) begin errors++; $display("FAIL miss_mem_addr: got %h expected %h", bus.mem_addr, addr); end
            checks++; if (bus.cpu_stall !== 1'b1 || bus.cache_we !== 1'b0) begin errors++; $display("FAIL miss_rdreq_stall: got stall=%b cache_we=%b expected 1/0", bus.cpu_stall, bus.cache_we); end
        end
        for (int i = 0; i <= resp_dly; i++) begin
            next_cycle();
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = (i == resp_dly);
            bus.mem_resp_data  = (i == resp_dly) ? data : 32'hBAD2_BAD2;
            #3;
            checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL miss_wait_mem_valid: got %b expected 0", bus.mem_req_valid); end
            checks++; if (bus.cpu_stall !== 1'b1 || bus.cache_we !== 1'b0) begin errors++; $display("FAIL miss_wait_stall: got stall=%b cache_we=%b expected 1/0", bus.cpu_stall, bus.cache_we); end
        end
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        #3;
        checks++; if (bus.cache_we !== 1'b1) begin errors++; $display("FAIL fill_cache_we: got %b expected 1", bus.cache_we); end
        checks++; if (bus.cache_addr !== addr) begin errors++; $display("FAIL fill_cache_addr: got %h expected %h", bus.cache_addr, addr); end
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL fill_stall: got %b expected 0", bus.cpu_stall); end
        checks++;
        if (q_rd.size() == 0) begin
            errors++; $display("FAIL fill_scoreboard: got empty queue expected entry");
        end else begin
            exp = q_rd.pop_front();
            if (bus.cpu_rdata !== exp || bus.cache_wdata !== exp) begin
                errors++; $display("FAIL fill_data: got rdata=%h wdata=%h expected %h", bus.cpu_rdata, bus.cache_wdata, exp);
            end
        end
    endtask

    task automatic test_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int nrdy);
        wr_t exp;
        next_cycle();
        idle_inputs();
        bus.cpu_req_valid = 1'b1;
        bus.cpu_we        = 1'b1;
        bus.cpu_addr      = addr;
        bus.cpu_wdata     = data;
        q_wr.push_back('{addr: addr, data: data});
        #3;
        checks++; if (bus.cache_we !== 1'b1) begin errors++; $display("FAIL wr_cache_we: got %b expected 1", bus.cache_we); end
        checks++; if (bus.cache_wdata !== data || bus.cache_addr !== addr) begin errors++; $display("FAIL wr_cache_port: got addr=%h data=%h expected %h/%h", bus.cache_addr, bus.cache_wdata, addr, data); end
        checks++; if (bus.cpu_stall !== 1'b1 || bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL wr_req_cycle: got stall=%b mem_valid=%b expected 1/0", bus.cpu_stall, bus.mem_req_valid); end
        for (int i = 0; i <= nrdy; i++) begin
            next_cycle();
            bus.mem_req_ready = (i == nrdy);
            #3;
            checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_req: got valid=%b we=%b expected 1/1", bus.mem_req_valid, bus.mem_we); end
            checks++; if (bus.cpu_stall !== (i != nrdy)) begin errors++; $display("FAIL wr_stall: got %b expected %b", bus.cpu_stall, (i != nrdy)); end
            checks++; if (bus.cache_we !== 1'b0) begin errors++; $display("FAIL wr_wait_cache_we: got %b expected 0", bus.cache_we); end
            checks++;
            if (q_wr.size() == 0) begin
                errors++; $display("FAIL wr_scoreboard: got empty queue expected entry");
            end else begin
                exp = (i == nrdy) ? q_wr.pop_front() : q_wr[0];
                if (bus.mem_addr !== exp.addr || bus.mem_wdata !== exp.data) begin
                    errors++; $display("FAIL wr_mem_fields: got addr=%h data=%h expected %h/%h", bus.mem_addr, bus.mem_wdata, exp.addr, exp.data);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        test_read_miss(32'h0000_0100, $urandom, 0, 0);
        test_read_hit(32'h0000_0104, 32'h0BAD_CAFE);
        test_write(32'h0000_0108, 32'h5A5A_0001, 0);
        test_read_miss(32'h0000_010C, 32'h7777_8888, 1, 0);
        test_write(32'h0000_0110, 32'h1234_0002, 2);
        test_read_hit(32'h0000_0114, 32'hFEED_F00D);
        idle_cycle();
    endtask

    task automatic test_reset_mid_miss();
        next_cycle();
        idle_inputs();
        bus.cpu_req_valid = 1'b1;
        bus.cpu_addr      = 32'h0000_0080;
        next_cycle();
        bus.mem_req_ready = 1'b1;
        next_cycle();
        bus.mem_req_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got valid=%b stall=%b expected 0/0", bus.mem_req_valid, bus.cpu_stall); end
        next_cycle();
        idle_inputs();
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'hCAFE_F00D;
            #3;
            checks++; if (bus.cache_we !== 1'b0) begin errors++; $display("FAIL late_resp_cache_we: got %b expected 0", bus.cache_we); end
            checks++; if (bus.cpu_stall !== 1'b0 || bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL late_resp_quiet: got stall=%b valid=%b expected 0/0", bus.cpu_stall, bus.mem_req_valid); end
        end
        // Still in IDLE: a hit completes immediately
        test_read_hit(32'h0000_0080, 32'h1111_2222);
        idle_cycle();
    endtask

`ifdef CACHE_PERF_CNT_EN
    task automatic test_perf_counters();
        next_cycle();
        idle_inputs();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        #3;
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL perf_reset: got hit=%0d miss=%0d expected 0/0", hit_count, miss_count); end
        test_read_hit(32'h0000_0200, 32'h0000_0001);
        test_read_miss(32'h0000_0204, 32'h0000_0002, 0, 1);
        test_read_hit(32'h0000_0208, 32'h0000_0003);
        test_write(32'h0000_020C, 32'h0000_0004, 1);
        test_read_miss(32'h0000_0210, 32'h0000_0005, 1, 0);
        test_read_hit(32'h0000_0214, 32'h0000_0006);
        idle_cycle();
        checks++; if (hit_count !== 32'd3) begin errors++; $display("FAIL perf_hit_count: got %0d expected 3", hit_count); end
        checks++; if (miss_count !== 32'd2) begin errors++; $display("FAIL perf_miss_count: got %0d expected 2", miss_count); end
    endtask
`endif

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_read_hit(32'h0000_0010, 32'hDEAD_BEEF);
        idle_cycle();
        idle_cycle();
        test_read_miss(32'h0000_0024, 32'h1234_5678, 2, 3);
        idle_cycle();
        test_write(32'h0000_0040, 32'hA5A5_A5A5, 4);
        idle_cycle();
        test_back_to_back();
        test_reset_mid_miss();
`ifdef CACHE_PERF_CNT_EN
        test_perf_counters();
`endif
        checks++;
        if (q_rd.size() != 0 || q_wr.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got rd=%0d wr=%0d expected 0/0", q_rd.size(), q_wr.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before limit");
        $fatal(1, "timeout");
    end
endmodule : tb_cache_refill_ctrl
`default_nettype wire
